// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS controller: a Moore FSM that sequences fetch, decode,
// memory, ALU, branch and jump steps over a shared memory, and keeps a
// sticky flag for unsupported opcodes and R-type function codes.
//
// Optional feature: define MC_BNE_EN to decode bne (op 000101). The
// instruction shares the BRANCH state with beq and inverts the zero test.
// Without the macro, bne is treated as an illegal opcode.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  // State encodings are visible on the debug port, so they are fixed.
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  // Raw strobes before the reset mask is applied.
  logic       pcen_raw, irwrite_raw, memwrite_raw, regwrite_raw;

  // Branch sense: beq takes the branch on zero, bne on not-zero.
  logic       branch_take;

`ifdef MC_BNE_EN
  assign branch_take = (op == OP_BNE) ? ~zero : zero;
`else
  assign branch_take = zero;
`endif

  // State and sticky illegal flag; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and illegal-flag update from the current state and inputs.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: begin
        state_d = S_ALUWB;
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: illegal_d = illegal_q;
          default:                               illegal_d = 1'b1;
        endcase
      end
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; anything not driven in a state stays at default.
  always_comb begin
    pcen_raw     = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        pcen_raw    = mem_ready;
        irwrite_raw = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_raw   = branch_take;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc    = 2'b10;
        pcen_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write strobes are suppressed while reset is held.
  assign pcen     = pcen_raw     & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: one record per clock cycle holding
// the inputs for that cycle and the outputs expected during it.
module tb_mips_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] wr;   // {pcen, irwrite, memwrite, regwrite}
    logic [3:0] sel;  // {iord, regdst, memtoreg, alusrca}
    logic [1:0] srcb;
    logic [1:0] pcs;
    logic [3:0] alu;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b111111;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;
  logic       illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;
  vec_t vq[$];

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic [3:0] st, input logic [3:0] wr,
                             input logic [3:0] sel, input logic [1:0] srcb,
                             input logic [1:0] pcs, input logic [3:0] alu,
                             input logic ill);
    out_t r;
    r.st = st; r.wr = wr; r.sel = sel; r.srcb = srcb;
    r.pcs = pcs; r.alu = alu; r.ill = ill;
    return r;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [5:0] opc,
                               input logic [5:0] fn, input logic z,
                               input logic mr, input out_t e);
    vec_t v;
    v.rst = rst; v.op = opc; v.fn = fn; v.z = z; v.mr = mr; v.exp = e;
    return v;
  endfunction

  task automatic add(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                     input logic z, input logic mr, input out_t e);
    vq.push_back(mkv(rst, opc, fn, z, mr, e));
  endtask

  // Drive one cycle's inputs after the falling edge and check the outputs
  // before the next rising edge.
  task automatic apply(input vec_t v);
    out_t got;
    @(negedge clk);
    reset = v.rst; op = v.op; funct = v.fn; zero = v.z; mem_ready = v.mr;
    #1;
    got = o(state, {pcen, irwrite, memwrite, regwrite},
            {iord, regdst, memtoreg, alusrca}, alusrcb, pcsrc, alucontrol, illegal);
    n_cmp++;
    if (got !== v.exp) begin
      n_bad++;
      $display("FAIL step %0d outputs: got st=%0d wr=%b sel=%b srcb=%b pcsrc=%b alu=%b ill=%b, required st=%0d wr=%b sel=%b srcb=%b pcsrc=%b alu=%b ill=%b",
               step_no, got.st, got.wr, got.sel, got.srcb, got.pcs, got.alu, got.ill,
               v.exp.st, v.exp.wr, v.exp.sel, v.exp.srcb, v.exp.pcs, v.exp.alu, v.exp.ill);
    end else begin
      $display("ok   step %0d rst=%b op=%b fn=%b z=%b mr=%b st=%0d wr=%b alu=%b ill=%b",
               step_no, v.rst, v.op, v.fn, v.z, v.mr, got.st, got.wr, got.alu, got.ill);
    end
    step_no++;
  endtask

  task automatic step(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                      input logic z, input logic mr, input out_t e);
    apply(mkv(rst, opc, fn, z, mr, e));
  endtask

  logic [5:0] fn_list[5];
  logic [3:0] alu_list[5];
  logic       bne_ill;

  initial begin
    fn_list[0] = F_ADD; alu_list[0] = A_ADD;
    fn_list[1] = F_SUB; alu_list[1] = A_SUB;
    fn_list[2] = F_AND; alu_list[2] = A_AND;
    fn_list[3] = F_OR;  alu_list[3] = A_OR;
    fn_list[4] = F_SLT; alu_list[4] = A_SLT;

    // Reset: strobes masked even though FETCH sees mem_ready=1.
    add(1, LW, 6'd0, 0, 1, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    // lw: 0,1,2,3,4 with regwrite/memtoreg only in MEMWB.
    add(0, LW, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, LW, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, LW, 6'd0, 0, 1, o(2, 4'b0000, 4'b0001, 2'b10, 2'b00, A_ADD, 0));
    add(0, LW, 6'd0, 0, 1, o(3, 4'b0000, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    add(0, LW, 6'd0, 0, 1, o(4, 4'b0001, 4'b0010, 2'b00, 2'b00, A_ADD, 0));
    // sw with a fetch wait and three MEMWR wait cycles.
    add(0, SW, 6'd0, 0, 0, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, SW, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, SW, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, SW, 6'd0, 0, 1, o(2, 4'b0000, 4'b0001, 2'b10, 2'b00, A_ADD, 0));
    for (int k = 0; k < 3; k++)
      add(0, SW, 6'd0, 0, 0, o(5, 4'b0010, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    add(0, SW, 6'd0, 0, 1, o(5, 4'b0010, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    // R-type with each supported funct.
    for (int k = 0; k < 5; k++) begin
      add(0, RT, fn_list[k], 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
      add(0, RT, fn_list[k], 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
      add(0, RT, fn_list[k], 0, 1, o(6, 4'b0000, 4'b0001, 2'b00, 2'b00, alu_list[k], 0));
      add(0, RT, fn_list[k], 0, 1, o(7, 4'b0001, 4'b0100, 2'b00, 2'b00, A_ADD, 0));
    end
    // addi.
    add(0, ADDI, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, ADDI, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, ADDI, 6'd0, 0, 1, o(9, 4'b0000, 4'b0001, 2'b10, 2'b00, A_ADD, 0));
    add(0, ADDI, 6'd0, 0, 1, o(10, 4'b0001, 4'b0000, 2'b00, 2'b00, A_ADD, 0));
    // beq taken, then not taken.
    add(0, BEQ, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, BEQ, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, BEQ, 6'd0, 1, 1, o(8, 4'b1000, 4'b0001, 2'b00, 2'b01, A_SUB, 0));
    add(0, BEQ, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, BEQ, 6'd0, 1, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, BEQ, 6'd0, 0, 1, o(8, 4'b0000, 4'b0001, 2'b00, 2'b01, A_SUB, 0));
    // j.
    add(0, JMP, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    add(0, JMP, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    add(0, JMP, 6'd0, 0, 1, o(11, 4'b1000, 4'b0000, 2'b00, 2'b10, A_ADD, 0));

    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++)
      apply(vq[i]);

    // bne: branch with inverted zero test, or an illegal opcode.
    step(0, BNE, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    step(0, BNE, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
`ifdef MC_BNE_EN
    step(0, BNE, 6'd0, 0, 1, o(8, 4'b1000, 4'b0001, 2'b00, 2'b01, A_SUB, 0));
    bne_ill = 1'b0;
`else
    bne_ill = 1'b1;
`endif
    step(0, BNE, 6'd0, 0, 0, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, bne_ill));
    // Reset clears the sticky flag; strobes masked during the reset cycle.
    step(1, LW, 6'd0, 0, 1, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, bne_ill));

    // Reset while waiting in MEMRD.
    step(0, LW, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    step(0, LW, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    step(0, LW, 6'd0, 0, 1, o(2, 4'b0000, 4'b0001, 2'b10, 2'b00, A_ADD, 0));
    step(0, LW, 6'd0, 0, 0, o(3, 4'b0000, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    step(1, LW, 6'd0, 0, 0, o(3, 4'b0000, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    step(0, LW, 6'd0, 0, 0, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, 0));

    // Reset while waiting in MEMWR: memwrite must drop in the reset cycle.
    step(0, SW, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    step(0, SW, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    step(0, SW, 6'd0, 0, 1, o(2, 4'b0000, 4'b0001, 2'b10, 2'b00, A_ADD, 0));
    step(0, SW, 6'd0, 0, 0, o(5, 4'b0010, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    step(1, SW, 6'd0, 0, 0, o(5, 4'b0000, 4'b1000, 2'b00, 2'b00, A_ADD, 0));
    step(0, SW, 6'd0, 0, 0, o(0, 4'b0000, 4'b0000, 2'b01, 2'b00, A_ADD, 0));

    // Unsupported funct: ADD in EXECUTE, flag set afterwards and kept,
    // sequencing of the following jump unaffected.
    step(0, RT, F_BAD, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 0));
    step(0, RT, F_BAD, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 0));
    step(0, RT, F_BAD, 0, 1, o(6, 4'b0000, 4'b0001, 2'b00, 2'b00, A_ADD, 0));
    step(0, RT, F_BAD, 0, 1, o(7, 4'b0001, 4'b0100, 2'b00, 2'b00, A_ADD, 1));
    step(0, JMP, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 1));
    step(0, JMP, 6'd0, 0, 1, o(1, 4'b0000, 4'b0000, 2'b11, 2'b00, A_ADD, 1));
    step(0, JMP, 6'd0, 0, 1, o(11, 4'b1000, 4'b0000, 2'b00, 2'b10, A_ADD, 1));
    step(0, JMP, 6'd0, 0, 1, o(0, 4'b1100, 4'b0000, 2'b01, 2'b00, A_ADD, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
